// File: rtl/wheel_pkg.sv
// Shared definitions for the wheel encoder chain: FSM encoding, step constants,
// the decoder's pin-state codes and the saturating-add helpers.
package wheel_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND_CW  = 2'd1,
    PEND_CCW = 2'd2
  } state_e;

  // Quadrature pin states {A,B} as the decoder sees them, in Gray order
  typedef enum logic [1:0] {
    PIN_00 = 2'b00,
    PIN_01 = 2'b01,
    PIN_11 = 2'b11,
    PIN_10 = 2'b10
  } pin_state_e;

  localparam logic signed [1:0] STEP_CW  = 2'sb01;
  localparam logic signed [1:0] STEP_CCW = 2'sb11;

  // Signed add clamped to the two's complement range of 'width' bits (width <= 31)
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] val,
                                                 input logic signed [31:0] step,
                                                 input int width);
    logic signed [31:0] lim_hi;
    logic signed [31:0] lim_lo;
    logic signed [31:0] sum;
    lim_hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lim_lo = -lim_hi - 32'sd1;
    sum    = val + step;
    if (sum > lim_hi) begin
      sat_add = lim_hi;
    end else if (sum < lim_lo) begin
      sat_add = lim_lo;
    end else begin
      sat_add = sum;
    end
  endfunction

  function automatic logic sat_hit(input logic signed [31:0] val,
                                   input logic signed [31:0] step,
                                   input int width);
    sat_hit = (sat_add(val, step, width) != (val + step));
  endfunction

endpackage

// File: rtl/wheel_odometer_if.sv
// Speed-sample handshake between the odometer (master) and the motion controller.
interface wheel_odometer_if #(
  parameter int SPD_W = 12
);
  logic signed [SPD_W-1:0] speed;
  logic                    speed_valid;
  logic                    speed_ready;

  modport master (output speed, output speed_valid, input speed_ready);
  modport slave  (input speed, input speed_valid, output speed_ready);
endinterface

// File: rtl/wheel_window_timer.sv
// Free-running sample-window counter 0..WIN_CYCLES-1; tick marks the terminal count.
module wheel_window_timer #(
  parameter int WIN_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int              CNT_W = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(WIN_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Window counter with wrap at terminal count and synchronous restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (restart) begin
      cnt_r <= '0;
    end else if (cnt_r == TERM) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = (cnt_r == TERM);

endmodule

// File: rtl/wheel_odometer.sv
// Turns decoder detent pulses into a saturating wheel position and per-window
// signed speed samples delivered over a valid/ready handshake.
module wheel_odometer
  import wheel_pkg::*;
#(
  parameter int POS_W      = 16,
  parameter int SPD_W      = 12,
  parameter int WIN_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dir_cw,
  input  logic                    dir_ccw,
  input  logic                    registra,
  input  logic                    clear,
  output logic signed [POS_W-1:0] position,
  output logic                    pos_sat,
  output logic                    seq_err,
  output logic                    overrun,
  wheel_odometer_if.master        spd
);

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic                    commit_s;
  logic                    seq_err_set_s;
  logic signed [1:0]       step_s;
  logic signed [POS_W-1:0] pos_sum_s;
  logic                    pos_hit_s;
  logic signed [SPD_W-1:0] acc_r;
  logic signed [SPD_W-1:0] acc_sum_s;
  logic                    win_tick_s;
  logic                    tick_s;
  logic                    xfer_s;

  wheel_window_timer #(
    .WIN_CYCLES (WIN_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (clear),
    .tick    (win_tick_s)
  );

  assign tick_s = win_tick_s && !clear;
  assign xfer_s = spd.speed_valid && spd.speed_ready;

  // Pending-direction state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else if (clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, commit request and sequence-error detection
  always_comb begin
    state_nxt_s   = state_r;
    commit_s      = 1'b0;
    seq_err_set_s = 1'b0;
    step_s        = STEP_CW;
    case (state_r)
      IDLE: begin
        seq_err_set_s = registra || (dir_cw && dir_ccw);
        if (dir_cw && dir_ccw) begin
          state_nxt_s = IDLE;
        end else if (dir_cw) begin
          state_nxt_s = PEND_CW;
        end else if (dir_ccw) begin
          state_nxt_s = PEND_CCW;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PEND_CW, PEND_CCW: begin
        step_s   = (state_r == PEND_CW) ? STEP_CW : STEP_CCW;
        commit_s = registra;
        // A new pulse while pending is legal only if the old one commits now
        if (dir_cw && dir_ccw) begin
          seq_err_set_s = 1'b1;
          state_nxt_s   = IDLE;
        end else if (dir_cw) begin
          seq_err_set_s = !registra;
          state_nxt_s   = PEND_CW;
        end else if (dir_ccw) begin
          seq_err_set_s = !registra;
          state_nxt_s   = PEND_CCW;
        end else if (registra) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign pos_sum_s = POS_W'(sat_add(32'(position), 32'(step_s), POS_W));
  assign pos_hit_s = commit_s && sat_hit(32'(position), 32'(step_s), POS_W);
  assign acc_sum_s = commit_s ? SPD_W'(sat_add(32'(acc_r), 32'(step_s), SPD_W)) : acc_r;

  // Position, window accumulator, speed sample and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      position        <= '0;
      acc_r           <= '0;
      pos_sat         <= 1'b0;
      seq_err         <= 1'b0;
      overrun         <= 1'b0;
      spd.speed       <= '0;
      spd.speed_valid <= 1'b0;
    end else if (clear) begin
      position <= '0;
      acc_r    <= '0;
      pos_sat  <= 1'b0;
      seq_err  <= 1'b0;
      overrun  <= 1'b0;
      if (xfer_s) begin
        spd.speed_valid <= 1'b0;
      end else begin
        spd.speed_valid <= spd.speed_valid;
      end
    end else begin
      if (commit_s) begin
        position <= pos_sum_s;
      end else begin
        position <= position;
      end
      pos_sat <= pos_sat || pos_hit_s;
      seq_err <= seq_err || seq_err_set_s;
      if (tick_s) begin
        spd.speed       <= acc_sum_s;
        acc_r           <= '0;
        spd.speed_valid <= 1'b1;
        overrun         <= overrun || (spd.speed_valid && !spd.speed_ready);
      end else begin
        acc_r <= acc_sum_s;
        if (xfer_s) begin
          spd.speed_valid <= 1'b0;
        end else begin
          spd.speed_valid <= spd.speed_valid;
        end
      end
    end
  end

endmodule

// File: doc/wheel_odometer.md
# wheel_odometer

Downstream consumer of the quadrature wheel decoder. Accepts the decoder's per-detent direction pulses (`dir_cw`, `dir_ccw`) and the commit strobe (`registra`), which follows one cycle later. Maintains a saturating signed wheel position and measures signed steps per fixed sample window (speed). Each speed sample is delivered to the motion controller over a valid/ready handshake.

## Interface
- `POS_W`, default 16: position width, signed two's complement.
- `SPD_W`, default 12: speed-sample width, signed two's complement.
- `WIN_CYCLES`, default 50_000_000: sample window length in clk cycles; minimum 2.
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `dir_cw`, input, 1: one-cycle pulse; clockwise detent detected.
- `dir_ccw`, input, 1: one-cycle pulse; counterclockwise detent detected.
- `registra`, input, 1: commit strobe, one cycle after `dir_*`.
- `clear`, input, 1: synchronous zeroing of `position` and the window accumulator.
- `position`, output, POS_W: accumulated signed detent count.
- `speed`, output, SPD_W: signed detents in the last completed window.
- `speed_valid`, output, 1: `speed` holds an unconsumed sample.
- `speed_ready`, input, 1: consumer accepts the sample.
- `pos_sat`, output, 1: sticky; position hit a limit. Cleared only by `clear` or `reset`.
- `seq_err`, output, 1: sticky; illegal pulse sequence. Cleared only by `clear` or `reset`.
- `overrun`, output, 1: sticky; a sample was overwritten before it was consumed. Cleared only by `clear` or `reset`.

## Operation
Pending FSM, states IDLE, PEND_CW, PEND_CCW. Reset state is IDLE.
- **IDLE:**
  - `dir_cw` alone goes to PEND_CW.
  - `dir_ccw` alone goes to PEND_CCW.
  - Both together: set `seq_err`, stay in IDLE.
  - `registra` alone: set `seq_err`, no commit.
- **PEND_x:**
  - `registra` commits the step (+1 for CW, −1 for CCW) and returns to IDLE.
  - A new `dir_*` without `registra` sets `seq_err`; the new pulse replaces the pending direction, or goes to IDLE if both pulses are high.
  - `registra` together with a new `dir_*`: commit the old step, then go to PEND of the new direction.
- **Commit, position:** saturating add. At +2^(POS_W−1)−1 a +1 holds the value and sets `pos_sat`. The negative limit behaves symmetrically.
- **Commit, window accumulator `acc`:** SPD_W wide, saturating the same way. Saturation here raises no flag.
- **Window timer:** counts 0..WIN_CYCLES−1 and wraps. The terminal count is the "tick".
- **On tick:**
  - `speed` <= `acc` including any commit in the same cycle.
  - `acc` <= 0.
  - `speed_valid` <= 1.
  - If `speed_valid` && !`speed_ready` in that cycle, set `overrun`; the new sample overwrites the old.
- **Handshake:** a transfer happens when `speed_valid` && `speed_ready` at a clk edge. `speed_valid` drops next cycle unless a tick happens in the same cycle, in which case it stays 1 with the new value and `overrun` is not set.
- **`clear`:**
  - Zeroes `position`, `acc`, `pos_sat`, `seq_err`, `overrun`.
  - Restarts the timer at 0 and forces the FSM to IDLE.
  - Leaves `speed`/`speed_valid` untouched.
  - Overrides a coincident commit or tick; the tick is suppressed.

## Timing
- Reset values: all outputs 0, FSM IDLE, timer 0, `acc` 0.
- All outputs registered. `position` reflects a commit the cycle after the `registra` edge, so latency is 1 clk from `registra`. Total from `dir_*` is 2 clk.
- `speed_valid` rises the cycle after the tick edge.
- Reset asserted mid-window or mid-PEND returns everything to reset values immediately (asynchronously). The first window after reset release is full length.
- Commits at rates up to one every 2 clk are supported without loss.

## Structure
- Shared package `wheel_pkg`:
  - FSM state encoding (IDLE/PEND_CW/PEND_CCW).
  - Step constants STEP_CW=+1, STEP_CCW=−1.
  - The decoder's pin-state codes, so encoder-side blocks share one definition.
- Sub-module `wheel_window_timer`:
  - Parameter WIN_CYCLES; ports clk, reset, restart.
  - Output `tick`, a one-cycle pulse at terminal count.
  - `$clog2(WIN_CYCLES)`-bit counter.
- Saturating add is a package function used for both `position` and `acc`.

## Test plan
The bench uses WIN_CYCLES=8, POS_W=4, SPD_W=4.
- Three CW pairs (`dir_cw`, then `registra` next cycle) -> `position`=3 one clk after each `registra`, in steps 1, 2, 3; `seq_err`=0.
- Position at 7, then another CW pair -> `position` stays 7, `pos_sat`=1. `clear` -> `position`=0, `pos_sat`=0.
- Two CCW pairs and one CW pair inside one window, `speed_ready`=1 -> at tick `speed`=−1 (4'hF), `speed_valid` high for exactly 1 cycle.
- `speed_ready`=0 across two ticks with 2 and then 1 CW steps -> `speed`=1, `speed_valid`=1, `overrun`=1.
- `registra` with no pending pulse, and `dir_cw`+`dir_ccw` together -> `seq_err`=1, `position` unchanged.
- Assert `reset` in PEND_CW, release, then `registra` -> no commit, `position`=0, `seq_err`=1.
